lcd_spi_writer: RTL



---
 rtl/lcd_pkg.sv | 25 ++
 rtl/lcd_spi_writer_if.sv | 37 +++
 rtl/lcd_tick_gen.sv | 40 ++++
 rtl/lcd_spi_writer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
//  Shared definitions for the 4-wire LCD serial writer.
//  - lcd_state_t : writer FSM states (IDLE, SETUP, SHIFT, HOLD, GAP)
//  - LCD_*_IDX   : bit positions of CS, SCL, A0 and SI on the lcd[3:0] pins
//  - LCD_IDLE    : pin value while no transfer is active (all high)
// ---------------------------------------------------------------------------
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } lcd_state_t;

  localparam int LCD_CS_IDX  = 0;  // chip select, active low
  localparam int LCD_SCL_IDX = 1;  // serial clock, LCD samples SI on rise
  localparam int LCD_A0_IDX  = 2;  // 1: display data, 0: command
  localparam int LCD_SI_IDX  = 3;  // serial data

  localparam logic [3:0] LCD_IDLE = 4'b1111;

endpackage

// File: rtl/lcd_spi_writer_if.sv
// ---------------------------------------------------------------------------
// lcd_spi_writer_if
//  Word handshake between the display controller and the LCD serial writer.
//  Valid/ready: a word moves on every rising clk edge where tx_valid and
//  tx_ready are both high. The master holds tx_valid, tx_data and tx_is_data
//  stable until that edge; the slave may raise or drop tx_ready freely and
//  never waits for tx_valid before asserting it.
//  Signals:
//    tx_valid   master -> slave  word available
//    tx_ready   slave  -> master word accepted on this edge when valid
//    tx_data    master -> slave  DATA_W-bit word
//    tx_is_data master -> slave  1: display data (A0=1), 0: command (A0=0)
// ---------------------------------------------------------------------------
interface lcd_spi_writer_if #(
  parameter int DATA_W = 8
) ();

  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_is_data;

  modport master (
    output tx_valid,
    output tx_data,
    output tx_is_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    input  tx_is_data,
    output tx_ready
  );

endinterface

// File: rtl/lcd_tick_gen.sv
// ---------------------------------------------------------------------------
// lcd_tick_gen
//  Divider producing one SCL half-period tick every CLK_DIV clk cycles while
//  enabled. The count is cleared whenever en is low, so the first tick after
//  enabling always arrives a full CLK_DIV cycles later.
//  Ports:
//    clk   in  system clock
//    rst_n in  async active-low reset
//    en    in  count enable (writer not idle)
//    tick  out high for the single cycle where the count is CLK_DIV-1
// ---------------------------------------------------------------------------
module lcd_tick_gen #(
  parameter int CLK_DIV = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/lcd_spi_writer.sv
// ---------------------------------------------------------------------------
// lcd_spi_writer
//  Serial writer for the 4-wire LCD port {SI,A0,SCL,CS}. Accepts one word per
//  valid/ready handshake and shifts it out with programmable SCL rate, CS
//  setup/hold/gap and bit order. All pin outputs are registered.
//
//  Frame (ticks of CLK_DIV clk cycles):
//    accept edge : CS low, A0 = word type
//    SETUP       : CS_SETUP ticks with SCL high, ends with the first SCL fall
//    SHIFT       : 2*DATA_W half periods, SI changes on SCL fall
//    HOLD        : SCL high for CS_HOLD ticks, then CS and SI return high
//    GAP         : CS high for CS_GAP ticks, then A0 high and tx_ready again
//
//  Optional build macro LCD_BURST_EN: tx_ready is also high in HOLD. A word
//  taken there keeps CS low and starts shifting on the next tick, skipping
//  the GAP/SETUP of a new frame. A0 changes while SCL is high.
//
//  Ports:
//    clk       in   system clock
//    rst_n     in   async active-low reset
//    tx        if   slave side of lcd_spi_writer_if (valid/ready/data/is_data)
//    busy      out  transfer in progress (state not IDLE)
//    lcd       out  lcd[0]=CS (active low), lcd[1]=SCL, lcd[2]=A0, lcd[3]=SI
//    dbg_state out  current FSM state
// ---------------------------------------------------------------------------
module lcd_spi_writer
  import lcd_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 250,
  parameter int CS_SETUP  = 1,
  parameter int CS_HOLD   = 1,
  parameter int CS_GAP    = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  lcd_spi_writer_if.slave     tx,
  output logic                busy,
  output logic [3:0]          lcd,
  output lcd_state_t          dbg_state
);

`ifdef LCD_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  localparam int BCW = $clog2(DATA_W + 1);
  localparam logic [BCW-1:0] BITS = BCW'(DATA_W);

  // Per-state tick counter; 16 bits covers any practical setup/hold/gap.
  localparam int TCW = 16;
  localparam logic [TCW-1:0] SETUP_LAST = TCW'(CS_SETUP - 1);
  localparam logic [TCW-1:0] HOLD_LAST  = TCW'(CS_HOLD - 1);
  localparam logic [TCW-1:0] GAP_LAST   = TCW'(CS_GAP - 1);

  lcd_state_t        state;
  logic [3:0]        lcd_q;
  logic              tx_ready_q;
  logic              busy_q;
  logic              pend;       // burst word accepted in HOLD, not yet shifting
  logic [DATA_W-1:0] shreg;      // bits still to send, next one at the output end
  logic [BCW-1:0]    bit_cnt;    // bits already placed on SI
  logic [TCW-1:0]    tcnt;
  logic              tick;
  logic              hs;
  logic [DATA_W-1:0] burst_word;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  lcd_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state != IDLE),
    .tick  (tick)
  );

  assign hs = tx.tx_valid && tx_ready_q;
  // A word accepted on the very edge that ends HOLD is shifted straight from the bus.
  assign burst_word = hs ? tx.tx_data : shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lcd_q      <= LCD_IDLE;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      pend       <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      tcnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            shreg              <= tx.tx_data;
            lcd_q[LCD_CS_IDX]  <= 1'b0;
            lcd_q[LCD_A0_IDX]  <= tx.tx_is_data;
            tx_ready_q         <= 1'b0;
            busy_q             <= 1'b1;
            tcnt               <= '0;
            state              <= SETUP;
          end else begin
            tx_ready_q <= 1'b1;
          end
        end

        SETUP: begin
          if (tick) begin
            if (tcnt == SETUP_LAST) begin
              tcnt               <= '0;
              lcd_q[LCD_SCL_IDX] <= 1'b0;
              lcd_q[LCD_SI_IDX]  <= first_bit(shreg);
              shreg              <= shift_out(shreg);
              bit_cnt            <= BCW'(1);
              state              <= SHIFT;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end

        SHIFT: begin
          if (tick) begin
            if (!lcd_q[LCD_SCL_IDX]) begin
              lcd_q[LCD_SCL_IDX] <= 1'b1;
            end else if (bit_cnt == BITS) begin
              // Last high half period done; SCL and SI stay as they are.
              tcnt       <= '0;
              tx_ready_q <= BURST_EN;
              state      <= HOLD;
            end else begin
              lcd_q[LCD_SCL_IDX] <= 1'b0;
              lcd_q[LCD_SI_IDX]  <= first_bit(shreg);
              shreg              <= shift_out(shreg);
              bit_cnt            <= bit_cnt + 1'b1;
            end
          end
        end

        HOLD: begin
          if (hs) begin
            shreg             <= tx.tx_data;
            lcd_q[LCD_A0_IDX] <= tx.tx_is_data;
            pend              <= 1'b1;
            tx_ready_q        <= 1'b0;
          end
          if (tick) begin
            if (pend || hs) begin
              lcd_q[LCD_SCL_IDX] <= 1'b0;
              lcd_q[LCD_SI_IDX]  <= first_bit(burst_word);
              shreg              <= shift_out(burst_word);
              bit_cnt            <= BCW'(1);
              pend               <= 1'b0;
              tx_ready_q         <= 1'b0;
              tcnt               <= '0;
              state              <= SHIFT;
            end else if (tcnt == HOLD_LAST) begin
              lcd_q[LCD_CS_IDX] <= 1'b1;
              lcd_q[LCD_SI_IDX] <= 1'b1;
              tx_ready_q        <= 1'b0;
              tcnt              <= '0;
              state             <= GAP;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end

        GAP: begin
          if (tick) begin
            if (tcnt == GAP_LAST) begin
              lcd_q[LCD_A0_IDX] <= 1'b1;
              busy_q            <= 1'b0;
              tx_ready_q        <= 1'b1;
              tcnt              <= '0;
              state             <= IDLE;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end

        default: begin
          lcd_q      <= LCD_IDLE;
          tx_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          pend       <= 1'b0;
          tcnt       <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign tx.tx_ready = tx_ready_q;
  assign busy        = busy_q;
  assign lcd         = lcd_q;
  assign dbg_state   = state;

endmodule
